// File: rtl/conv_out_framer.sv
// -----------------------------------------------------------------------------
// conv_out_framer
//
// Downstream stage of conv2d_3x3. Takes the raw signed 16-bit pixel stream,
// clamps each pixel to 0..2^PIX_BITS-1, tags start-of-frame (m_tuser) and
// end-of-line (m_tlast), and presents the result on an AXI-Stream master.
// A 2-entry skid buffer sits between the two handshakes so that s_tready is a
// plain register with no combinational path from m_tready.
//
// Optional feature macro: FRAMER_SAT_STATS_EN
//   When defined, adds output sat_count (32 bits): number of pixels clamped in
//   the current frame, cleared on an accepted frame_start, saturating at
//   0xFFFFFFFF. When undefined the port and its logic are absent.
//
// Ports:
//   sys_clk      clock
//   sys_rst      asynchronous active-high reset
//   frame_start  one-cycle pulse; arms a frame and latches cfg_cols/cfg_rows
//   cfg_cols     pixels per row (0 illegal)
//   cfg_rows     rows per frame (0 illegal)
//   s_tdata      signed input pixel
//   s_tvalid     input valid
//   s_tready     input ready (registered)
//   m_tdata      clamped pixel, zero-extended
//   m_tvalid     output valid
//   m_tready     output ready
//   m_tuser      SOF tag, first pixel of a frame
//   m_tlast      EOL tag, last pixel of each row
//   frame_done   one-cycle pulse after the frame's last pixel leaves
//   busy         high while the frame is being accepted (ACTIVE)
//   err_overrun  sticky: input valid seen while idle; cleared by frame_start
//   sat_count    (FRAMER_SAT_STATS_EN only) clamped-pixel count
// -----------------------------------------------------------------------------
module conv_out_framer #(
  parameter int DWIDTH   = 16,
  parameter int PIX_BITS = 10,
  parameter int CNT_W    = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              frame_start,
  input  logic [CNT_W-1:0]  cfg_cols,
  input  logic [CNT_W-1:0]  cfg_rows,
  input  logic [DWIDTH-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DWIDTH-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic              frame_done,
  output logic              busy,
  output logic              err_overrun
`ifdef FRAMER_SAT_STATS_EN
  ,
  output logic [31:0]       sat_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cols_q, rows_q;
  logic [CNT_W-1:0]   col_q, row_q;

  // Skid buffer: entry 0 is the head and drives the m_* outputs.
  logic [PIX_BITS-1:0] buf_data [2];
  logic                buf_user [2];
  logic                buf_last [2];
  logic [1:0]          occ;

  logic                accept, pop;
  logic                last_col, last_row, frame_end_accept;
  logic                enter_active, leave_done, next_active;
  logic [1:0]          occ_nx;
  logic                wr_slot;
  logic                tag_user;
  logic                is_neg, is_over;
  logic [PIX_BITS-1:0] pix;

  // ---------------------------------------------------------------------------
  // Handshakes and frame-position decode
  // ---------------------------------------------------------------------------
  assign accept   = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;
  assign m_tvalid = (occ != 2'd0);

  assign last_col         = (col_q == cols_q - CNT_W'(1));
  assign last_row         = (row_q == rows_q - CNT_W'(1));
  assign tag_user         = (col_q == '0) && (row_q == '0);
  assign frame_end_accept = accept && last_col && last_row;

  assign enter_active = (state == S_IDLE) && frame_start;
  // The last beat can only leave in DONE, and by then it is the sole entry.
  assign leave_done   = (state == S_DONE) && pop && (occ == 2'd1);
  assign next_active  = enter_active || ((state == S_ACTIVE) && !frame_end_accept);

  assign occ_nx  = occ + 2'(accept) - 2'(pop);
  // With one entry and no pop, the new beat queues behind the head; in every
  // other legal case it lands in the head slot (after any shift).
  assign wr_slot = (occ == 2'd1) && !pop;

  // ---------------------------------------------------------------------------
  // Clamp: negative -> 0; any magnitude bit above the pixel range -> max.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pix     = s_tdata[PIX_BITS-1:0];
    is_neg  = s_tdata[DWIDTH-1];
    is_over = |s_tdata[DWIDTH-2:PIX_BITS];
    if (is_neg) begin
      pix = '0;
    end else if (is_over) begin
      pix = '1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM with registered control outputs. s_tready and busy are loaded
  // with the value they must carry in the next cycle, so s_tready always
  // equals (state==ACTIVE && occupancy<2) without looking at m_tready.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only; reset is async assert via the sensitivity list.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= S_IDLE;
      cols_q      <= '0;
      rows_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      s_tready    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      frame_done <= leave_done;
      busy       <= next_active;
      s_tready   <= next_active && (occ_nx != 2'd2);
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state       <= S_ACTIVE;
            cols_q      <= cfg_cols;
            rows_q      <= cfg_rows;
            col_q       <= '0;
            row_q       <= '0;
            err_overrun <= 1'b0;
          end else if (s_tvalid) begin
            err_overrun <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (accept) begin
            if (last_col) begin
              col_q <= '0;
              if (last_row) begin
                row_q <= '0;
                state <= S_DONE;
              end else begin
                row_q <= row_q + CNT_W'(1);
              end
            end else begin
              col_q <= col_q + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (leave_done) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer. A pop shifts entry 1 into the head; a push written later in
  // the same block overrides the shift when it targets the head slot.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      occ <= 2'd0;
      // NOTE: the buffer storage is reset too, because the head entry drives m_tdata/m_tuser/m_tlast directly.
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_user[i] <= 1'b0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      occ <= occ_nx;
      if (pop) begin
        buf_data[0] <= buf_data[1];
        buf_user[0] <= buf_user[1];
        buf_last[0] <= buf_last[1];
      end
      if (accept) begin
        buf_data[wr_slot] <= pix;
        buf_user[wr_slot] <= tag_user;
        buf_last[wr_slot] <= last_col;
      end
    end
  end

  assign m_tdata = DWIDTH'(buf_data[0]);
  assign m_tuser = buf_user[0];
  assign m_tlast = buf_last[0];

`ifdef FRAMER_SAT_STATS_EN
  // Clamped-pixel counter for the current frame; holds after the frame ends.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sat_count <= '0;
    end else if (enter_active) begin
      sat_count <= '0;
    end else if (accept && (is_neg || is_over) && (sat_count != 32'hFFFF_FFFF)) begin
      sat_count <= sat_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_out_framer.sv
// -----------------------------------------------------------------------------
// tb_conv_out_framer
//
// Directed bench for conv_out_framer. Each driven pixel pushes its expected
// clamped value and tags into a scoreboard queue; a negedge monitor pops and
// compares every beat that completes on the master side, and also checks the
// s_tready/occupancy relation, output stability under stall and frame_done.
// -----------------------------------------------------------------------------
module tb_conv_out_framer;

  localparam int DW = 16;
  localparam int PB = 10;
  localparam int CW = 12;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          frame_start;
  logic [CW-1:0] cfg_cols, cfg_rows;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tuser, m_tlast;
  logic          frame_done, busy, err_overrun;
`ifdef FRAMER_SAT_STATS_EN
  logic [31:0]   sat_count;
`endif

  conv_out_framer #(.DWIDTH(DW), .PIX_BITS(PB), .CNT_W(CW)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .frame_start (frame_start),
    .cfg_cols    (cfg_cols),
    .cfg_rows    (cfg_rows),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tuser     (m_tuser),
    .m_tlast     (m_tlast),
    .frame_done  (frame_done),
    .busy        (busy),
    .err_overrun (err_overrun)
`ifdef FRAMER_SAT_STATS_EN
    ,
    .sat_count   (sat_count)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] data;
    logic        user;
    logic        last;
    logic        eof;
  } beat_t;

  beat_t       sb[$];
  int          tests = 0;
  int          fails = 0;
  int          occ_model = 0;
  int          done_cnt = 0;
  logic        done_pending = 1'b0;
  logic        rand_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_user, prev_last;
  logic [15:0] clamp_tbl [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference clamp on the signed integer value.
  function automatic logic [15:0] ref_clamp(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0)    return 16'd0;
    if (s > 1023) return 16'd1023;
    return 16'(s);
  endfunction

  // Random downstream ready for the backpressure frame.
  always @(posedge sys_clk) begin
    #1;
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
  end

  // Monitor: sample mid-cycle, judge the handshakes that complete at the next posedge.
  always @(negedge sys_clk) begin
    beat_t e;
    if (sys_rst) begin
      occ_model    = 0;
      prev_stall   = 1'b0;
      done_pending = 1'b0;
    end else begin
      if (done_pending || frame_done) begin
        check("frame_done", 32'(frame_done), 32'(done_pending));
        if (frame_done) done_cnt++;
      end
      done_pending = 1'b0;
      check("s_tready_occ", 32'(s_tready), 32'(busy && (occ_model < 2)));
      if (prev_stall) begin
        check("hold_data", 32'(m_tdata), 32'(prev_data));
        check("hold_tags", {29'd0, m_tvalid, m_tuser, m_tlast}, {29'd0, 1'b1, prev_user, prev_last});
      end
      if (m_tvalid && m_tready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("m_tdata", 32'(m_tdata), 32'(e.data));
          check("m_tuser", 32'(m_tuser), 32'(e.user));
          check("m_tlast", 32'(m_tlast), 32'(e.last));
          done_pending = e.eof;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_user  = m_tuser;
      prev_last  = m_tlast;
      occ_model  = occ_model + int'(s_tvalid && s_tready) - int'(m_tvalid && m_tready);
    end
  end

  // Arms a frame and feeds its beats; returns early after stop_after accepts.
  // mode 0: constant 5, mode 1: clamp table by column, other: varied data.
  task automatic send_frame(input int cols, input int rows, input int mode, input int stop_after);
    int          idx;
    logic        hs;
    logic [15:0] v;
    beat_t       b;
    idx = 0;
    cfg_cols    = CW'(cols);
    cfg_rows    = CW'(rows);
    frame_start = 1'b1;
    @(posedge sys_clk); #1;
    frame_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared", 32'(err_overrun), 32'd0);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        case (mode)
          0:       v = 16'h0005;
          1:       v = clamp_tbl[c];
          default: v = 16'(idx * 37 + r);
        endcase
        s_tdata  = v;
        s_tvalid = 1'b1;
        b.data = ref_clamp(v);
        b.user = (r == 0) && (c == 0);
        b.last = (c == cols - 1);
        b.eof  = (r == rows - 1) && (c == cols - 1);
        sb.push_back(b);
        hs = 1'b0;
        for (int t = 0; t < 200 && !hs; t++) begin
          @(negedge sys_clk);
          hs = s_tready;
          @(posedge sys_clk); #1;
        end
        check("accept_timeout", 32'(hs), 32'd1);
        if (idx == 0) check("latency", 32'(m_tvalid), 32'd1);
        idx++;
        if (idx == stop_after) return;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input int exp_done);
    for (int t = 0; t < 500 && sb.size() != 0; t++) @(negedge sys_clk);
    repeat (3) @(negedge sys_clk);
    check("drain", 32'(sb.size()), 32'd0);
    check("frame_done_count", 32'(done_cnt), 32'(exp_done));
    check("idle_after_frame", {30'd0, busy, s_tready}, 32'd0);
  endtask

  initial begin
    clamp_tbl[0] = 16'hFFFF;
    clamp_tbl[1] = 16'h8000;
    clamp_tbl[2] = 16'h03FF;
    clamp_tbl[3] = 16'h0400;
    clamp_tbl[4] = 16'h7FFF;

    // Reset with input valid and output ready.
    sys_rst     = 1'b1;
    frame_start = 1'b0;
    cfg_cols    = '0;
    cfg_rows    = '0;
    s_tdata     = 16'h0123;
    s_tvalid    = 1'b1;
    m_tready    = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("rst_ctrl", {25'd0, s_tready, m_tvalid, m_tuser, m_tlast, frame_done, busy, err_overrun}, 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("err_overrun_idle", 32'(err_overrun), 32'd1);
    check("idle_no_ready", 32'(s_tready), 32'd0);

    // 4x2 frame of constant 5.
    send_frame(4, 2, 0, -1);
    drain(1);

    // Clamp boundaries in a 5x1 frame.
    send_frame(5, 1, 1, -1);
    drain(2);
`ifdef FRAMER_SAT_STATS_EN
    check("sat_count", sat_count, 32'd4);
`endif

    // Backpressure over a 2448x4 frame with continuous input valid.
    rand_ready = 1'b1;
    send_frame(2448, 4, 2, -1);
    drain(3);
    @(negedge sys_clk);
    rand_ready = 1'b0;
    m_tready   = 1'b1;

    // Reset in the middle of a 40x4 frame at row 2, column 37.
    send_frame(40, 4, 2, 2 * 40 + 38);
    sys_rst  = 1'b1;
    s_tvalid = 1'b0;
    @(negedge sys_clk);
    check("midrst_ctrl", {25'd0, s_tready, m_tvalid, m_tuser, m_tlast, frame_done, busy, err_overrun}, 32'd0);
    check("midrst_tdata", 32'(m_tdata), 32'd0);
    sb.delete();
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // Fresh frame after the reset starts cleanly with SOF on its first beat.
    send_frame(3, 2, 2, -1);
    drain(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_out_framer.md
Name: conv_out_framer

Overview:
- Downstream stage of conv2d_3x3. Consumes its raw 16-bit output stream, clamps each pixel to the 10-bit PGM range (0..1023) and tags frame/line boundaries (SOF on TUSER, EOL on TLAST).
- Drives a backpressure-capable AXI-Stream master toward the writer/DMA.
- A 2-entry skid buffer decouples upstream TREADY from downstream TREADY, so conv2d_3x3 never sees a combinational ready path.

Parameters:
- DWIDTH, 16, width of input and output TDATA.
- PIX_BITS, 10, clamp ceiling width; max value 2^PIX_BITS-1 (1023).
- CNT_W, 12, width of column/row counters and config ports.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  asynchronous active-high reset.
- frame_start  in  1  one-cycle pulse; arms a new frame and latches cfg_cols/cfg_rows.
- cfg_cols  in  CNT_W  pixels per row (2448 nominal); 0 is illegal.
- cfg_rows  in  CNT_W  rows per frame (2048 nominal); 0 is illegal.
- s_tdata  in  DWIDTH  pixel from conv2d_3x3 output_r_TDATA, interpreted signed.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready (drives conv2d_3x3 output_r_TREADY).
- m_tdata  out  DWIDTH  clamped pixel, zero-extended.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tuser  out  1  SOF; set on the first pixel of a frame.
- m_tlast  out  1  EOL; set on the last pixel of each row.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted downstream.
- busy  out  1  high in ACTIVE.
- err_overrun  out  1  sticky; a pixel arrived in IDLE. Cleared by frame_start.

Behaviour:
- Reset (async assert, sync release): state=IDLE; counters=0; skid empty; s_tready=0, m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=0, frame_done=0, busy=0, err_overrun=0.
- FSM IDLE -> ACTIVE on frame_start:
  - latch cfg_cols/cfg_rows;
  - col=0, row=0;
  - clear err_overrun.
- FSM ACTIVE -> DONE when the input beat with col=cols-1 and row=rows-1 is accepted. DONE -> IDLE once the skid buffer drains and that beat is accepted downstream; frame_done pulses on that cycle.
- frame_start outside IDLE is ignored.
- Input handshake:
  - s_tready = (state==ACTIVE) && skid occupancy < 2.
  - s_tready is registered; no combinational path from m_tready.
  - Accept occurs on s_tvalid && s_tready.
- In IDLE, s_tready=0. If s_tvalid=1 in IDLE, set err_overrun; the data is neither consumed nor dropped.
- Clamp, applied at accept:
  - signed s_tdata < 0 -> 0;
  - > 2^PIX_BITS-1 -> 2^PIX_BITS-1;
  - otherwise pass through.
  - Upper bits of m_tdata are always 0.
- Tagging, applied at accept:
  - tuser = (col==0 && row==0);
  - tlast = (col==cols-1).
  - col wraps to 0 at cols-1 and row increments at the wrap. Tags travel with the data through the skid buffer.
- Skid buffer:
  - 2 entries, FIFO order; the head drives the m_* outputs.
  - Simultaneous push and pop keeps occupancy unchanged.
  - m_tvalid is deasserted only when the buffer is empty.
  - While m_tvalid=1 && m_tready=0, the m_* outputs are held stable (AXI rule).
- Latency: 1 cycle from input accept to m_tvalid when the buffer is empty and m_tready=1. Sustained throughput is 1 pixel/cycle.
- Counters never overflow: cols/rows are fixed for the frame, and no input is accepted in DONE.
- Reset mid-frame: everything clears immediately, and the partial frame is discarded.

Optional Feature:
- Macro: FRAMER_SAT_STATS_EN.
- Defined:
  - adds output port sat_count (32 bits). It counts the pixels clamped (low or high) in the current frame.
  - It is cleared on frame_start and holds its value after DONE until the next frame_start.
  - It saturates at 0xFFFFFFFF.
- Undefined: the port and its logic are absent; the block is otherwise identical.

Test Plan:
- Reset with s_tvalid=1 and m_tready=1 -> all outputs 0, s_tready=0. After 3 cycles, err_overrun=1 (IDLE with valid input).
- cfg_cols=4, cfg_rows=2, frame_start, 8 beats of data 0x0005 with m_tready=1:
  - m_tdata=5 on all 8 beats;
  - m_tuser on beat 0 only; m_tlast on beats 3 and 7;
  - frame_done one cycle after beat 7 is accepted.
- Clamp: inputs 0xFFFF, 0x8000, 0x03FF, 0x0400, 0x7FFF -> outputs 0, 0, 1023, 1023, 1023. With FRAMER_SAT_STATS_EN defined, sat_count=4.
- Backpressure, with s_tvalid=1 continuously:
  - m_tready toggles 1-0-0-1 randomly over a 2448x4 frame;
  - every pixel appears exactly once and in order;
  - m_tdata is stable while stalled;
  - s_tready drops only when 2 entries are held.
- Full frame 2448x2048 fed from the hex reference through conv2d_3x3 with m_tready=1:
  - 5,013,504 beats; 2048 TLASTs; 1 TUSER;
  - output matches the PGM golden clamped values.
- Assert sys_rst at row 100 col 37 -> outputs clear within 1 cycle. The next frame_start begins cleanly with tuser on its first beat.
